// File: rtl/clock_enable_gen.sv
// -----------------------------------------------------------------------------
// clock_enable_gen
//
// Purpose:
//    Produces NUM_CH single-cycle clock-enable strobes from one system clock,
//    each one firing every div[i] cycles. The strobes, and a downstream reset,
//    are released only after the PLL has been locked for RST_HOLD cycles.
//    Loss of lock drops the block back to waiting for lock.
//
//    Sequencing:  WAIT_LOCK --lock--> HOLD (RST_HOLD cycles) --> RUN
//    Losing lock in any state returns to WAIT_LOCK.
//
// Parameters:
//    NUM_CH     number of clock-enable channels (1..8)
//    CNT_WIDTH  divisor / counter width in bits
//    DIV_INIT   divisor loaded into every channel on reset
//    RST_HOLD   cycles spent in HOLD after lock is seen (>= 2)
//
// Ports:
//    clock       in   system clock, all state changes on its rising edge
//    resetn      in   asynchronous active-low reset
//    pll_lock    in   PLL lock indicator, asynchronous to clock
//    div_wr      in   divisor write strobe, one cycle per write
//    div_sel     in   channel index for div_wr (indices >= NUM_CH are ignored)
//    div_value   in   new divisor for channel div_sel
//    ce          out  per-channel single-cycle clock-enable strobes
//    sys_resetn  out  downstream reset, asserted asynchronously and
//                     deasserted synchronously one cycle after RUN is entered
//    ready       out  high while the block is in RUN (same timing as sys_resetn)
// -----------------------------------------------------------------------------
module clock_enable_gen #(
   parameter int NUM_CH    = 4,
   parameter int CNT_WIDTH = 16,
   parameter int DIV_INIT  = 1,
   parameter int RST_HOLD  = 1024
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 pll_lock,
   input  logic                 div_wr,
   input  logic [2:0]           div_sel,
   input  logic [CNT_WIDTH-1:0] div_value,
   output logic [NUM_CH-1:0]    ce,
   output logic                 sys_resetn,
   output logic                 ready
);

   localparam int                   HOLD_W    = $clog2(RST_HOLD);
   localparam logic [HOLD_W-1:0]    HOLD_LOAD = HOLD_W'(RST_HOLD - 1);
   localparam logic [CNT_WIDTH-1:0] DIV_RST   = CNT_WIDTH'(DIV_INIT);

   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_HOLD      = 2'd1,
      ST_RUN       = 2'd2
   } state_t;

   // --------------------------------------------------------------------------
   // Lock synchroniser (two flops, pll_lock is asynchronous to clock)
   // --------------------------------------------------------------------------
   logic sync1_q;
   logic lock_s_q;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync1_q  <= 1'b0;
         lock_s_q <= 1'b0;
      end else begin
         sync1_q  <= pll_lock;
         lock_s_q <= sync1_q;
      end
   end

   // --------------------------------------------------------------------------
   // Lock / hold sequencer
   // --------------------------------------------------------------------------
   state_t            state_q;
   state_t            state_d;
   logic [HOLD_W-1:0] hold_q;
   logic [HOLD_W-1:0] hold_d;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_WAIT_LOCK;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      if (!lock_s_q) begin
         // Losing lock overrides every other transition.
         state_d = ST_WAIT_LOCK;
      end else begin
         case (state_q)
            ST_WAIT_LOCK: begin
               state_d = ST_HOLD;
               hold_d  = HOLD_LOAD;
            end
            ST_HOLD: begin
               // Counter visits HOLD_LOAD..0, so HOLD lasts RST_HOLD cycles.
               if (hold_q == '0) begin
                  state_d = ST_RUN;
               end else begin
                  hold_d = hold_q - HOLD_W'(1);
               end
            end
            ST_RUN: begin
               state_d = ST_RUN;
            end
            default: begin
               state_d = ST_WAIT_LOCK;
            end
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Registered run indication: drives both ready and sys_resetn. The async
   // reset clears it immediately; release happens on a clock edge.
   // --------------------------------------------------------------------------
   logic in_run;
   logic run_q;
   logic run_d;

   assign in_run = (state_q == ST_RUN);
   assign run_d  = in_run;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         run_q <= 1'b0;
      end else begin
         run_q <= run_d;
      end
   end

   assign ready      = run_q;
   assign sys_resetn = run_q;

   // --------------------------------------------------------------------------
   // Per-channel divisor register, down-counter and registered strobe.
   //
   // Counters sit at 0 outside RUN, so every enabled channel fires in the
   // first RUN cycle and the first strobes line up with ready rising.
   // A divisor write only changes the value loaded at the next reload, so the
   // period in progress always completes. A disabled channel (div=0) holds its
   // counter at 0, which makes a newly written divisor fire straight away.
   // --------------------------------------------------------------------------
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_WIDTH-1:0] div_q;
      logic [CNT_WIDTH-1:0] div_d;
      logic [CNT_WIDTH-1:0] cnt_q;
      logic [CNT_WIDTH-1:0] cnt_d;
      logic                 ce_q;
      logic                 ce_d;

      // Selects outside 0..NUM_CH-1 match no channel and are dropped.
      always_comb begin
         div_d = div_q;
         if (div_wr && (div_sel == 3'(gi))) begin
            div_d = div_value;
         end
      end

      always_comb begin
         cnt_d = cnt_q;
         ce_d  = 1'b0;
         if (!in_run || (div_q == '0)) begin
            cnt_d = '0;
         end else if (cnt_q == '0) begin
            ce_d  = 1'b1;
            cnt_d = div_q - CNT_WIDTH'(1);
         end else begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
         end
      end

      always_ff @(posedge clock or negedge resetn) begin
         if (!resetn) begin
            div_q <= DIV_RST;
            cnt_q <= '0;
            ce_q  <= 1'b0;
         end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
            ce_q  <= ce_d;
         end
      end

      assign ce[gi] = ce_q;
   end

endmodule

// File: tb/tb_clock_enable_gen.sv
// -----------------------------------------------------------------------------
// tb_clock_enable_gen
//
// Self-checking bench for clock_enable_gen. A behavioural model tracks, per
// clock edge, how long lock has been continuously present (ready follows from
// that run length) and, per channel, the absolute cycle of the next due
// strobe. One process compares the DUT against the model on every edge.
// Directed scenarios pin the model with hand-computed literal expectations,
// then a randomized phase exercises writes and lock drops.
// -----------------------------------------------------------------------------
module tb_clock_enable_gen;

   localparam int NUM_CH    = 4;
   localparam int CNT_WIDTH = 16;
   localparam int DIV_INIT  = 1;
   localparam int RST_HOLD  = 16;

   logic                 clock     = 1'b0;
   logic                 resetn    = 1'b0;
   logic                 pll_lock  = 1'b0;
   logic                 div_wr    = 1'b0;
   logic [2:0]           div_sel   = 3'd0;
   logic [CNT_WIDTH-1:0] div_value = '0;
   logic [NUM_CH-1:0]    ce;
   logic                 sys_resetn;
   logic                 ready;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   clock_enable_gen #(
      .NUM_CH    (NUM_CH),
      .CNT_WIDTH (CNT_WIDTH),
      .DIV_INIT  (DIV_INIT),
      .RST_HOLD  (RST_HOLD)
   ) dut (
      .clock      (clock),
      .resetn     (resetn),
      .pll_lock   (pll_lock),
      .div_wr     (div_wr),
      .div_sel    (div_sel),
      .div_value  (div_value),
      .ce         (ce),
      .sys_resetn (sys_resetn),
      .ready      (ready)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // -------------------------------------------------------------------------
   // Behavioural model + per-cycle compare
   //   streak_h[k] : consecutive edges pll_lock was sampled high, k edges ago.
   //   Two sync flops plus one state flop plus the output flop mean ready at
   //   edge n reflects the lock run length at edge n-3; RUN needs the lock to
   //   have been seen on RST_HOLD+1 consecutive edges.
   //   due_m[i]    : absolute edge number of the channel's next strobe.
   // -------------------------------------------------------------------------
   longint            cyc = 0;
   int                streak_h [4];
   int                div_m [NUM_CH];
   longint            due_m [NUM_CH];
   logic              rdy_e = 1'b0;
   logic [NUM_CH-1:0] ce_e  = '0;

   always @(posedge clock) begin
      int sel_i;
      int old;
      if (!resetn) begin
         for (int k = 0; k < 4; k++) streak_h[k] = 0;
         for (int i = 0; i < NUM_CH; i++) begin
            div_m[i] = DIV_INIT;
            due_m[i] = 0;
         end
         rdy_e = 1'b0;
         ce_e  = '0;
      end else begin
         cyc++;
         for (int k = 3; k > 0; k--) streak_h[k] = streak_h[k-1];
         if (pll_lock) streak_h[0] = (streak_h[1] >= RST_HOLD + 1) ? RST_HOLD + 1 : streak_h[1] + 1;
         else          streak_h[0] = 0;
         rdy_e = (streak_h[3] >= RST_HOLD + 1);
         for (int i = 0; i < NUM_CH; i++) begin
            old = div_m[i];
            if (!rdy_e || old == 0) begin
               ce_e[i]  = 1'b0;
               due_m[i] = cyc + 1;
            end else if (cyc == due_m[i]) begin
               ce_e[i]  = 1'b1;
               due_m[i] = cyc + old;
            end else begin
               ce_e[i]  = 1'b0;
            end
         end
         sel_i = div_sel;
         if (div_wr && sel_i < NUM_CH) div_m[sel_i] = int'(div_value);
      end
      #1;
      check("model_ready", ready, rdy_e);
      check("model_sys_resetn", sys_resetn, rdy_e);
      check("model_ce", ce, ce_e);
   end

   // -------------------------------------------------------------------------
   // Stimulus helpers (called at a negedge, return at a negedge)
   // -------------------------------------------------------------------------
   task automatic write_div(input int sel, input int val);
      div_wr    = 1'b1;
      div_sel   = 3'(sel);
      div_value = CNT_WIDTH'(val);
      $display("write ch=%0d val=%0d t=%0t", sel, val, $time);
      @(negedge clock);
      div_wr = 1'b0;
   endtask

   // Counts edges (first edge after the call is 1) until ready is seen high.
   task automatic wait_ready(input string name, input int exp_k);
      int k;
      k = 0;
      for (int n = 1; n <= 200; n++) begin
         @(negedge clock);
         if (ready === 1'b1) begin
            k = n;
            break;
         end
      end
      check(name, k, exp_k);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int j;
      int found;
      logic [3:0] exp_v;

      // Reset state
      repeat (3) @(negedge clock);
      check("rst_ready", ready, 1'b0);
      check("rst_sys_resetn", sys_resetn, 1'b0);
      check("rst_ce", ce, 4'b0000);
      resetn = 1'b1;
      @(negedge clock);

      // Divisors {1,2,3,0} programmed while waiting for lock
      write_div(0, 1);
      write_div(1, 2);
      write_div(2, 3);
      write_div(3, 0);
      repeat (2) @(negedge clock);
      check("wait_lock_ready", ready, 1'b0);

      // Lock seen on edge 1 -> ready on edge 1 + 2 + RST_HOLD + 1 = 20
      pll_lock = 1'b1;
      wait_ready("lock_to_ready", 20);
      check("first_ce_aligned", ce, 4'b0111);

      // Strobe pattern relative to the first ready cycle (j = 0)
      for (j = 1; j <= 11; j++) begin
         @(negedge clock);
         exp_v = {1'b0, (j % 3 == 0), (j % 2 == 0), 1'b1};
         check("pattern", ce, exp_v);
      end
      // Out-of-range select must change nothing
      write_div(NUM_CH, 9);
      exp_v = {1'b0, (j % 3 == 0), (j % 2 == 0), 1'b1};
      check("pattern_bad_sel", ce, exp_v);
      for (j = 13; j <= 23; j++) begin
         @(negedge clock);
         exp_v = {1'b0, (j % 3 == 0), (j % 2 == 0), 1'b1};
         check("pattern_after_bad_sel", ce, exp_v);
      end

      // Channel 1 at div=5, rewritten to 2 two cycles after a strobe:
      // next strobe 5 after the old one (3 after the write), then every 2.
      write_div(1, 5);
      found = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clock);
         if (ce[1] === 1'b1) begin
            found = 1;
            break;
         end
      end
      check("ch1_pulse_found", found, 1);
      @(negedge clock);
      write_div(1, 2);
      for (int off = 3; off <= 9; off++) begin
         @(negedge clock);
         check("ch1_retime", ce[1], (off == 5 || off == 7 || off == 9));
      end

      // One-cycle lock drop: ready falls 3 edges later, then full re-hold
      pll_lock = 1'b0;
      @(negedge clock);
      pll_lock = 1'b1;
      @(negedge clock);
      check("drop_ready_e1", ready, 1'b1);
      @(negedge clock);
      check("drop_ready_e2", ready, 1'b1);
      @(negedge clock);
      check("drop_ready_e3", ready, 1'b0);
      check("drop_ce_e3", ce, 4'b0000);
      wait_ready("relock_to_ready", 17);
      check("relock_ce", ce, 4'b0111);

      // Async reset mid-RUN after writing div[2]=7
      write_div(2, 7);
      @(negedge clock);
      #2;
      resetn = 1'b0;
      #1;
      check("async_sys_resetn", sys_resetn, 1'b0);
      check("async_ready", ready, 1'b0);
      check("async_ce", ce, 4'b0000);
      @(negedge clock);
      resetn = 1'b1;
      wait_ready("reset_relock", 20);
      check("reset_div_init_ce", ce, 4'b1111);
      for (int n = 0; n < 3; n++) begin
         @(negedge clock);
         check("div2_back_to_init", ce[2], 1'b1);
      end

      // Randomized writes and occasional lock drops, checked by the model
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            div_wr    = 1'b1;
            div_sel   = 3'($urandom_range(0, 7));
            div_value = CNT_WIDTH'($urandom_range(0, 6));
            $display("write ch=%0d val=%0d t=%0t", div_sel, div_value, $time);
         end else begin
            div_wr = 1'b0;
         end
         pll_lock = ($urandom_range(0, 299) != 0);
         @(negedge clock);
      end
      div_wr   = 1'b0;
      pll_lock = 1'b1;
      repeat (5) @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/clock_enable_gen.md
CLOCK_ENABLE_GEN -- requirements
Module: clock_enable_gen

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of clock-enable channels (legal range 1..8).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, meaning the divisor and counter width in bits.
REQ-003 The block SHALL have parameter DIV_INIT, default 1, meaning the reset divisor of every channel.
REQ-004 The block SHALL have parameter RST_HOLD, default 1024, meaning the number of clock cycles that sys_resetn stays low after lock is seen (legal range >= 2).
REQ-005 The block SHALL have one clock and an asynchronous active-low reset, ports clock and resetn.
REQ-006 clock  in  1  single system clock; all state changes on its rising edge.
REQ-007 resetn  in  1  asynchronous active-low reset.
REQ-008 pll_lock  in  1  PLL lock indicator, asynchronous to clock.
REQ-009 div_wr  in  1  divisor write strobe, one cycle per write.
REQ-010 div_sel  in  3  channel index for div_wr.
REQ-011 div_value  in  CNT_WIDTH  new divisor for channel div_sel.
REQ-012 ce  out  NUM_CH  per-channel single-cycle clock-enable strobes.
REQ-013 sys_resetn  out  1  downstream reset: asserted asynchronously, deasserted synchronously.
REQ-014 ready  out  1  high while the state is RUN.

Function
REQ-015 pll_lock SHALL pass through a 2-flop synchroniser; lock_s denotes the synchronised value.
REQ-016 The FSM SHALL have three states: WAIT_LOCK, HOLD, RUN.
REQ-017 WAIT_LOCK -> HOLD when lock_s=1; the hold counter loads RST_HOLD-1.
REQ-018 HOLD: the hold counter decrements each cycle; HOLD -> RUN on the cycle after it reads 0.
REQ-019 In any state, lock_s=0 SHALL force the next state to WAIT_LOCK; this takes priority over every other transition.
REQ-020 sys_resetn and ready SHALL be registered, equal to (state==RUN), and change one cycle after the state register changes.
REQ-021 Each channel i SHALL hold a divisor register div[i] and a down-counter cnt[i], both CNT_WIDTH bits wide.
REQ-022 In RUN with div[i]>=1: when cnt[i]==0, ce[i]=1 that cycle and cnt[i] reloads div[i]-1; otherwise ce[i]=0 and cnt[i] decrements.
REQ-023 Resulting ce[i] period: exactly div[i] cycles; div[i]=1 gives ce[i] continuously high.
REQ-024 div[i]=0 SHALL disable channel i: ce[i]=0 and cnt[i] held at 0.
REQ-025 Outside RUN, all cnt SHALL be held at 0 and ce SHALL be all zero.
REQ-026 With ready=1, the first ce pulse of every enabled channel SHALL occur together, in the first cycle that ready=1.
REQ-027 div_wr with div_sel<NUM_CH SHALL update div[div_sel] on the next edge in any state.
REQ-028 div_sel>=NUM_CH SHALL be ignored.
REQ-029 A new divisor SHALL take effect at the channel's next reload; the running period is not truncated (glitch-free).
REQ-030 Exception to REQ-029: when the old divisor was 0, the new divisor SHALL take effect immediately; cnt=0, so ce fires on the next RUN cycle.
REQ-031 ce SHALL be registered outputs.
REQ-032 The divisor arithmetic SHALL be unsigned and SHALL wrap modulo 2^CNT_WIDTH, with no saturation.

Reset
REQ-033 While resetn=0, the block SHALL be in this state: state=WAIT_LOCK, sync flops=0, hold counter=0, cnt=0, div=DIV_INIT, ce=0, sys_resetn=0, ready=0.
REQ-034 When resetn is asserted during RUN, sys_resetn and ready SHALL fall with no clock edge required.
REQ-035 After resetn is released, the block SHALL restart the full lock/hold sequence.
REQ-036 Divisor writes made before reset SHALL be lost on reset.

Verification
REQ-037 Scenario: RST_HOLD=16, pll_lock rises at cycle 10 -> ready and sys_resetn rise at cycle 10+2+16+1 (+/-0); ce[0]=1 in that same cycle.
REQ-038 Scenario: div = {1,2,3,0} in RUN -> ce[0] always 1; ce[1] every 2nd cycle; ce[2] every 3rd cycle; ce[3] never; first pulses aligned.
REQ-039 Scenario: channel 1 running at div=5, write div=2 two cycles after a pulse -> next pulse 3 cycles later, then every 2 cycles.
REQ-040 Scenario: pll_lock drops for 1 cycle in RUN -> ready falls 3 cycles later; ce all 0; full HOLD of RST_HOLD cycles repeated.
REQ-041 Scenario: resetn pulsed low mid-RUN with div[2]=7 written -> sys_resetn=0 immediately; after release, div[2]=DIV_INIT.
REQ-042 Scenario: div_wr with div_sel=NUM_CH and value 9 -> no divisor changes; all ce patterns unchanged.
